// File: rtl/mux2_pipe_if.sv
// ---------------------------------------------------------------------------
// mux2_pipe_if
// Bus bundle for the registered 2:1 selector mux2_pipe.
//
// Signals:
//   input0, input1  candidate data words (DATA_WIDTH bits)
//   select          0 picks input0, 1 picks input1
//   in_valid        qualifies input0/input1/select for this cycle
//   out_data        registered selected data
//   out_valid       high for the cycle after an accepted in_valid
//   out_sel         registered select value that produced out_data
// With MUX2_PIPE_SEL_CNT_EN defined:
//   clr_cnt         synchronous clear of both selection counters
//   sel0_cnt        saturating count of accepted transfers with select=0
//   sel1_cnt        saturating count of accepted transfers with select=1
//
// Modports: master drives the inputs, slave is the mux2_pipe side.
// ---------------------------------------------------------------------------
interface mux2_pipe_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] input0;
    logic [DATA_WIDTH-1:0] input1;
    logic                  select;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_sel;
`ifdef MUX2_PIPE_SEL_CNT_EN
    logic                  clr_cnt;
    logic [15:0]           sel0_cnt;
    logic [15:0]           sel1_cnt;
`endif

    modport master (
        output input0,
        output input1,
        output select,
        output in_valid,
`ifdef MUX2_PIPE_SEL_CNT_EN
        output clr_cnt,
        input  sel0_cnt,
        input  sel1_cnt,
`endif
        input  out_data,
        input  out_valid,
        input  out_sel
    );

    modport slave (
        input  input0,
        input  input1,
        input  select,
        input  in_valid,
`ifdef MUX2_PIPE_SEL_CNT_EN
        input  clr_cnt,
        output sel0_cnt,
        output sel1_cnt,
`endif
        output out_data,
        output out_valid,
        output out_sel
    );
endinterface

// File: rtl/mux2_pipe.sv
// ---------------------------------------------------------------------------
// mux2_pipe
// Registered 2:1 data selector. The word chosen by select is registered and
// presented one clock later together with out_valid and the select value
// that produced it. out_data/out_sel hold when no transfer is accepted.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mux2_pipe_if.slave: input0, input1, select, in_valid in;
//          out_data, out_valid, out_sel out
//
// Parameters:
//   DATA_WIDTH   data width in bits (1..1024)
//   RESET_VALUE  out_data reset value, truncated/zero-extended to DATA_WIDTH
//
// Optional feature (macro MUX2_PIPE_SEL_CNT_EN): adds clr_cnt, sel0_cnt and
// sel1_cnt to the bus -- saturating 16-bit counts of accepted transfers per
// select value; clr_cnt zeroes both and wins over a same-cycle transfer.
// ---------------------------------------------------------------------------
module mux2_pipe #(
    parameter int unsigned   DATA_WIDTH  = 32,
    parameter logic [1023:0] RESET_VALUE = '0
) (
    input  logic       clk,
    input  logic       rst_n,
    mux2_pipe_if.slave bus
);

    // Wide parameter sliced down so any override width is accepted and
    // truncated/zero-extended consistently.
    localparam logic [DATA_WIDTH-1:0] RST_DATA = RESET_VALUE[DATA_WIDTH-1:0];

    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= RST_DATA;
            valid_q <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                data_q <= bus.select ? bus.input1 : bus.input0;
                sel_q  <= bus.select;
            end
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_sel   = sel_q;

`ifdef MUX2_PIPE_SEL_CNT_EN
    logic [15:0] cnt0_q;
    logic [15:0] cnt1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (bus.clr_cnt) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (bus.in_valid) begin
            // Saturate at all-ones instead of wrapping.
            if (!bus.select && (cnt0_q != '1)) begin
                cnt0_q <= cnt0_q + 16'd1;
            end
            if (bus.select && (cnt1_q != '1)) begin
                cnt1_q <= cnt1_q + 16'd1;
            end
        end
    end

    assign bus.sel0_cnt = cnt0_q;
    assign bus.sel1_cnt = cnt1_q;
`endif

endmodule

// File: tb/tb_mux2_pipe.sv
// ---------------------------------------------------------------------------
// tb_mux2_pipe
// Directed bench for mux2_pipe. Each accepted transfer pushes its expected
// output into a scoreboard queue; the entry is popped and compared when the
// registered output appears one cycle later. Idle cycles are checked against
// the last accepted value (hold behaviour).
// ---------------------------------------------------------------------------
module tb_mux2_pipe;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic          sel;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    int            total = 0;
    int            bad = 0;
    exp_t          sbq[$];
    logic [DW-1:0] hold_data;
    logic          hold_sel;

    always #5 clk = ~clk;

    mux2_pipe_if #(.DATA_WIDTH(DW)) bus ();

    mux2_pipe #(
        .DATA_WIDTH (DW),
        .RESET_VALUE('0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sbq.delete();
        hold_data = '0;
        hold_sel  = 1'b0;
    endtask

    task automatic push_exp(input logic s, input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_t e;
        e.sel     = s;
        e.data    = s ? b : a;
        hold_data = e.data;
        hold_sel  = s;
        sbq.push_back(e);
    endtask

    // Compare outputs after an edge against the scoreboard / hold model.
    task automatic observe();
        exp_t e;
        logic exp_v;
        exp_v = (sbq.size() != 0);
        chk("out_valid", DW'(bus.out_valid), DW'(exp_v));
        if (exp_v) begin
            e = sbq.pop_front();
            chk("out_data", bus.out_data, e.data);
            chk("out_sel", DW'(bus.out_sel), DW'(e.sel));
        end else begin
            chk("hold_data", bus.out_data, hold_data);
            chk("hold_sel", DW'(bus.out_sel), DW'(hold_sel));
        end
    endtask

    task automatic step(input logic v, input logic s, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.in_valid = v;
        bus.select   = s;
        bus.input0   = a;
        bus.input1   = b;
        if (v) push_exp(s, a, b);
        @(posedge clk);
        #1;
        observe();
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.select   = 1'b0;
        bus.input0   = '0;
        bus.input1   = '0;
`ifdef MUX2_PIPE_SEL_CNT_EN
        bus.clr_cnt  = 1'b0;
`endif
        model_reset();

        // Reset values with no clock edge yet.
        #1;
        chk("rst_data", bus.out_data, '0);
        chk("rst_valid", DW'(bus.out_valid), '0);
        chk("rst_sel", DW'(bus.out_sel), '0);

        // Release mid-cycle; first edge is idle.
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        observe();

        // Basic selection and patterns, back to back.
        step(1'b1, 1'b0, 32'h0000_0001, 32'h0000_0010);
        step(1'b1, 1'b1, 32'h0000_0001, 32'h0000_0010);
        step(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hAAAA_5555);
        step(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hAAAA_5555);
        // Hold with changing inputs while in_valid=0.
        step(1'b0, 1'b0, 32'h1111_1111, 32'h2222_2222);
        step(1'b0, 1'b1, 32'h3333_3333, 32'h4444_4444);
        chk("hold_pattern", bus.out_data, 32'hAAAA_5555);

        // Glitch on select between edges: only the edge value matters.
        bus.in_valid = 1'b1;
        bus.select   = 1'b1;
        bus.input0   = 32'hCAFE_0000;
        bus.input1   = 32'h0000_BEEF;
        #2;
        bus.select   = 1'b0;
        push_exp(1'b0, 32'hCAFE_0000, 32'h0000_BEEF);
        @(posedge clk);
        #1;
        observe();

        // Glitch on in_valid: pulse that ends before the edge is not a transfer.
        bus.in_valid = 1'b1;
        bus.select   = 1'b1;
        #2;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        observe();

        // Random stream with mixed valid/idle cycles.
        for (int i = 0; i < 24; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
        end

        // Mid-stream reset clears outputs immediately.
        step(1'b1, 1'b1, 32'h0, 32'h5A5A_1234);
        bus.in_valid = 1'b1;
        bus.select   = 1'b1;
        bus.input1   = 32'h7777_8888;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_data", bus.out_data, '0);
        chk("midrst_valid", DW'(bus.out_valid), '0);
        chk("midrst_sel", DW'(bus.out_sel), '0);
        // Held in reset across an edge with in_valid still high.
        @(posedge clk);
        #1;
        chk("inrst_valid", DW'(bus.out_valid), '0);
        chk("inrst_data", bus.out_data, '0);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        @(posedge clk);
        #1;
        observe();
        step(1'b1, 1'b1, 32'h0, 32'h0BAD_F00D);
        step(1'b0, 1'b0, 32'h0, 32'h0);

`ifdef MUX2_PIPE_SEL_CNT_EN
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        chk("cnt_rst0", DW'(bus.sel0_cnt), '0);
        chk("cnt_rst1", DW'(bus.sel1_cnt), '0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'(i), 32'hF0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 32'(i), 32'hF1);
        step(1'b0, 1'b0, 32'h0, 32'h0);
        chk("cnt_sel0", DW'(bus.sel0_cnt), 32'd3);
        chk("cnt_sel1", DW'(bus.sel1_cnt), 32'd2);
        // Clear wins over a same-cycle transfer.
        bus.clr_cnt = 1'b1;
        step(1'b1, 1'b1, 32'h0, 32'h1);
        bus.clr_cnt = 1'b0;
        chk("clr_sel0", DW'(bus.sel0_cnt), '0);
        chk("clr_sel1", DW'(bus.sel1_cnt), '0);
        for (int i = 0; i < 65540; i++) begin
            bus.in_valid = 1'b1;
            bus.select   = 1'b1;
            @(posedge clk);
        end
        bus.in_valid = 1'b0;
        #1;
        chk("sat_sel1", DW'(bus.sel1_cnt), 32'h0000_FFFF);
        chk("sat_sel0", DW'(bus.sel0_cnt), '0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
